// File: rtl/data_mem_resp_pkg.sv
`default_nettype none
// ============================================================================
// Package     : definitions
// Description : Shared RV32I load/store funct3 codes, the data-memory
//               responder state type and a funct3 legality helper.
// Revision    : 1.0 - initial release
// ============================================================================
package definitions;

  // Load funct3 codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store funct3 codes
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  // True when funct3 names a real access of the given direction.
  function automatic logic f3_legal(input logic we, input logic [2:0] funct3);
    logic ok;
    ok = 1'b0;
    if (we) begin
      ok = (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
    end else begin
      case (funct3)
        F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: ok = 1'b1;
        default:                             ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_resp_array.sv
`default_nettype none
// ============================================================================
// Module      : dmem_array
// Description : Single-port DEPTH_WORDS x 32 RAM with per-byte write enables
//               and a synchronous read. Contents are not reset.
// Ports       : clk   - rising-edge clock
//               en    - port enable (read and/or write this edge)
//               be    - byte-lane write enables, bit i covers bits 8i+7:8i
//               addr  - word address
//               wdata - write data, already placed on its lanes
//               rdata - word read at the last enabled edge (pre-write value)
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // rdata only updates on enabled edges, so it holds steady while the
  // responder sits in RESP.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
      rdata <= mem[addr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/data_mem_resp.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_resp
// Description : Load/store responder for the RV32I memory stage. Accepts one
//               request, waits LATENCY cycles, commits the byte-lane access
//               to a word RAM and holds the response until the core takes it.
// Ports       : clk, rst_n (sync, active-low)
//               req_valid/req_ready       - request handshake
//               req_we, req_funct3        - direction and access size/sign
//               req_addr, req_wdata       - byte address, right-aligned data
//               resp_valid/resp_ready     - response handshake
//               resp_rdata                - extended load data (0 otherwise)
//               resp_err                  - misaligned/illegal/out-of-range
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_resp
  import definitions::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  mem_state_t  r_state;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [2:0]  r_f3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_valid;
  logic        r_err;

  logic        w_accept;
  logic        w_commit;
  logic        w_we;
  logic [2:0]  w_f3;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic        w_misaligned;
  logic        w_out_of_range;
  logic        w_err;
  logic [3:0]  w_be;
  logic [31:0] w_lane_wdata;
  logic [31:0] w_ram_rdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext;

  assign req_ready = (r_state == IDLE) && rst_n;
  assign w_accept  = req_valid && req_ready;

  // With LATENCY == 1 the commit edge is the accept edge, so the access is
  // built straight from the request ports; otherwise from the latched copy.
  assign w_we    = (r_state == IDLE) ? req_we     : r_we;
  assign w_f3    = (r_state == IDLE) ? req_funct3 : r_f3;
  assign w_addr  = (r_state == IDLE) ? req_addr   : r_addr;
  assign w_wdata = (r_state == IDLE) ? req_wdata  : r_wdata;

  assign w_commit = rst_n &&
                    (((r_state == IDLE) && w_accept && (LATENCY == 1)) ||
                     ((r_state == WAIT) && (r_cnt == 4'd0)));

  assign w_misaligned   = ((w_f3[1:0] == 2'b01) && w_addr[0]) ||
                          ((w_f3[1:0] == 2'b10) && (w_addr[1:0] != 2'b00));
  assign w_out_of_range = (w_addr[31:AW+2] != '0);
  assign w_err          = !f3_legal(w_we, w_f3) || w_misaligned || w_out_of_range;

  always_comb begin
    w_be         = 4'b0000;
    w_lane_wdata = w_wdata;
    case (w_f3[1:0])
      2'b00: begin
        w_be         = 4'b0001 << w_addr[1:0];
        w_lane_wdata = {4{w_wdata[7:0]}};
      end
      2'b01: begin
        w_be         = w_addr[1] ? 4'b1100 : 4'b0011;
        w_lane_wdata = {2{w_wdata[15:0]}};
      end
      2'b10:   w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (AW)
  ) u_array (
    .clk   (clk),
    .en    (w_commit),
    .be    ((w_we && !w_err) ? w_be : 4'b0000),
    .addr  (w_addr[AW+1:2]),
    .wdata (w_lane_wdata),
    .rdata (w_ram_rdata)
  );

  // Extraction uses the latched request, which stays put through RESP.
  assign w_byte = w_ram_rdata[{r_addr[1:0], 3'b000} +: 8];
  assign w_half = r_addr[1] ? w_ram_rdata[31:16] : w_ram_rdata[15:0];

  always_comb begin
    w_ext = 32'h0;
    case (r_f3)
      F3_LB:   w_ext = {{24{w_byte[7]}}, w_byte};
      F3_LH:   w_ext = {{16{w_half[15]}}, w_half};
      F3_LW:   w_ext = w_ram_rdata;
      F3_LBU:  w_ext = {24'h0, w_byte};
      F3_LHU:  w_ext = {16'h0, w_half};
      default: w_ext = 32'h0;
    endcase
  end

  assign resp_valid = r_valid;
  assign resp_err   = r_err;
  assign resp_rdata = (r_valid && !r_err && !r_we) ? w_ext : 32'h0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_we    <= req_we;
            r_f3    <= req_funct3;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            if (LATENCY == 1) begin
              r_state <= RESP;
            end else begin
              r_state <= WAIT;
              r_cnt   <= 4'(LATENCY - 2);
            end
          end
        end
        WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
      if (w_commit) begin
        r_valid <= 1'b1;
        r_err   <= w_err;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_resp.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_resp
// Description : Directed self-checking bench for data_mem_resp (LATENCY=4,
//               64-word RAM).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_resp;

  localparam int LAT   = 4;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int total = 0;
  int bad   = 0;

  data_mem_resp #(
    .DEPTH_WORDS (DEPTH),
    .LATENCY     (LAT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Presents a request, waits for the accept edge, then counts edges until
  // resp_valid is seen. resp_valid rises at edge k+LAT-1 so the core samples
  // it at edge k+LAT.
  task automatic issue(input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd);
    int n;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    req_valid  = 1'b1;
    chk("req_ready_idle", {31'h0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("resp_valid_seen", {31'h0, resp_valid}, 32'd1);
    chk("latency", n, LAT - 1);
  endtask

  task automatic retire();
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic xfer(input string tag, input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err);
    issue(we, f3, addr, wd);
    chk({tag, "_rdata"}, resp_rdata, exp_rd);
    chk({tag, "_err"}, {31'h0, resp_err}, {31'h0, exp_err});
    retire();
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    resp_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'h0, resp_valid}, 32'd0);
    chk("rst_err",   {31'h0, resp_err},   32'd0);
    chk("rst_rdata", resp_rdata,          32'h0);
    chk("rst_ready", {31'h0, req_ready},  32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", {31'h0, req_ready}, 32'd1);

    // Word / byte loads
    xfer("sw10",  1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0);
    xfer("lw10",  1'b0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0);
    xfer("lb13",  1'b0, 3'b000, 32'h13, 32'h0,        32'hFFFFFFDE, 1'b0);
    xfer("lbu13", 1'b0, 3'b100, 32'h13, 32'h0,        32'h000000DE, 1'b0);

    // Halfwords
    xfer("sw20",  1'b1, 3'b010, 32'h20, 32'h12345678, 32'h0,        1'b0);
    xfer("sh22",  1'b1, 3'b001, 32'h22, 32'h00008001, 32'h0,        1'b0);
    xfer("lh22",  1'b0, 3'b001, 32'h22, 32'h0,        32'hFFFF8001, 1'b0);
    xfer("lhu22", 1'b0, 3'b101, 32'h22, 32'h0,        32'h00008001, 1'b0);
    xfer("lw20",  1'b0, 3'b010, 32'h20, 32'h0,        32'h80015678, 1'b0);

    // Errors
    xfer("lw11_mis",  1'b0, 3'b010, 32'h11, 32'h0,    32'h0,        1'b1);
    xfer("sh23_mis",  1'b1, 3'b001, 32'h23, 32'hFFFF, 32'h0,        1'b1);
    xfer("lw20_keep", 1'b0, 3'b010, 32'h20, 32'h0,    32'h80015678, 1'b0);
    xfer("ld_f3_011", 1'b0, 3'b011, 32'h10, 32'h0,    32'h0,        1'b1);
    xfer("st_f3_100", 1'b1, 3'b100, 32'h20, 32'h0,    32'h0,        1'b1);

    // Byte store into lane 1, then positive LB
    xfer("sb11",  1'b1, 3'b000, 32'h11, 32'h0000007F, 32'h0,        1'b0);
    xfer("lb11",  1'b0, 3'b000, 32'h11, 32'h0,        32'h0000007F, 1'b0);

    // Stalled response: outputs hold and no new accept
    issue(1'b0, 3'b010, 32'h10, 32'h0);
    for (int i = 0; i < 5; i++) begin
      chk("stall_rdata", resp_rdata,              32'hDEAD7FEF);
      chk("stall_err",   {31'h0, resp_err},       32'd0);
      chk("stall_valid", {31'h0, resp_valid},     32'd1);
      chk("stall_ready", {31'h0, req_ready},      32'd0);
      @(posedge clk); #1;
    end
    retire();

    // Reset while a store waits: the store must be dropped
    xfer("sw40", 1'b1, 3'b010, 32'h40, 32'h11223344, 32'h0, 1'b0);
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h40;
    req_wdata  = 32'hAAAAAAAA;
    req_valid  = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n     = 1'b0;
    @(posedge clk); #1;
    chk("midrst_valid", {31'h0, resp_valid}, 32'd0);
    chk("midrst_err",   {31'h0, resp_err},   32'd0);
    chk("midrst_rdata", resp_rdata,          32'h0);
    chk("midrst_ready", {31'h0, req_ready},  32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_ready_rel", {31'h0, req_ready}, 32'd1);
    xfer("lw40", 1'b0, 3'b010, 32'h40, 32'h0, 32'h11223344, 1'b0);

    // Out of range (4*DEPTH aliases word 0 in the low index bits)
    xfer("sw0",    1'b1, 3'b010, 32'h0,       32'hCAFEF00D, 32'h0,        1'b0);
    xfer("sw_oor", 1'b1, 3'b010, 32'(4*DEPTH), 32'h0BADBEEF, 32'h0,       1'b1);
    xfer("lw_oor", 1'b0, 3'b010, 32'(4*DEPTH), 32'h0,        32'h0,       1'b1);
    xfer("lw0",    1'b0, 3'b010, 32'h0,       32'h0,        32'hCAFEF00D, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
